interrupt_ctrl: RTL

Coprocessor-0-lite interrupt and exception receiver. It consumes peripheral interrupt lines, including the memory-mapped timer's interrupt output, and applies software masking. It decides when the core takes an interrupt or exception and saves and restores the return PC. It sits beside the decode/writeback stage, serving MFC0/MTC0 and ERET, and drives the PC mux.

---
 rtl/cp0_pkg.sv | 28 ++
 rtl/interrupt_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0-lite register indices, bit positions and cause codes
package cp0_pkg;

   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;

   localparam int IE_BIT  = 0;
   localparam int EXL_BIT = 1;
   localparam int IM_LSB  = 8;
   localparam int IM_MSB  = 15;
   localparam int EXC_LSB = 2;
   localparam int EXC_MSB = 6;

   typedef enum logic [4:0] {
      EXC_INT     = 5'd0,
      EXC_SYSCALL = 5'd8,
      EXC_BREAK   = 5'd9,
      EXC_RI      = 5'd10,
      EXC_OV      = 5'd12
   } exc_code_t;

   typedef enum logic {
      NORMAL  = 1'b0,
      HANDLER = 1'b1
   } cp0_state_t;

endpackage

// File: rtl/interrupt_ctrl.sv
// rtl/interrupt_ctrl.sv - interrupt/exception receiver with Status, Cause and EPC
module interrupt_ctrl
   import cp0_pkg::*;
#(
   parameter int               width           = 64,
   parameter logic [width-1:0] exceptionVector = 64'h80000180
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       hw_irq,
   input  logic [4:0]       regnum,
   input  logic [width-1:0] wr_data,
   input  logic             MTC0,
   input  logic             ERET,
   input  logic             Exception,
   input  logic [4:0]       exc_code,
   input  logic             Stall,
   input  logic [width-1:0] next_pc,
   output logic [width-1:0] rd_data,
   output logic             TakenInterrupt,
   output logic [width-1:0] EPC,
   output logic [width-1:0] handler_pc
);

   cp0_state_t       state_q, state_d;
   logic [7:0]       im_q, im_d;
   logic             ie_q, ie_d;
   logic [5:0]       ip_hw_q;
   logic [1:0]       ip_sw_q, ip_sw_d;
   logic [4:0]       exc_code_q, exc_code_d;
   logic [width-1:0] epc_q, epc_d;

   logic             pending;
   logic             take_exc;
   logic             take_int;
   logic [15:0]      status_v;
   logic [15:0]      cause_v;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= NORMAL;
         im_q       <= '0;
         ie_q       <= 1'b0;
         ip_hw_q    <= '0;
         ip_sw_q    <= '0;
         exc_code_q <= '0;
         epc_q      <= '0;
      end else begin
         state_q    <= state_d;
         im_q       <= im_d;
         ie_q       <= ie_d;
         ip_hw_q    <= hw_irq;
         ip_sw_q    <= ip_sw_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   // Take decision looks only at registered state, so a same-cycle MTC0 or ERET cannot affect it.
   always_comb begin
      pending  = |({ip_hw_q, ip_sw_q} & im_q);
      take_exc = !Stall && Exception;
      take_int = !Stall && !Exception && (state_q == NORMAL) && pending && ie_q;
   end

   always_comb begin
      state_d    = state_q;
      im_d       = im_q;
      ie_d       = ie_q;
      ip_sw_d    = ip_sw_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;

      if (MTC0) begin
         case (regnum)
            REG_STATUS: begin
               im_d    = wr_data[IM_MSB:IM_LSB];
               ie_d    = wr_data[IE_BIT];
               state_d = wr_data[EXL_BIT] ? HANDLER : NORMAL;
            end
            REG_CAUSE: ip_sw_d = wr_data[IM_LSB+1:IM_LSB];
            REG_EPC:   epc_d   = wr_data;
            default:   ;
         endcase
      end

      if (ERET) begin
         state_d = NORMAL;
      end

      if (take_exc || take_int) begin
         state_d    = HANDLER;
         exc_code_d = take_exc ? exc_code : EXC_INT;
         if (state_q == NORMAL) begin
            epc_d = next_pc;
         end
      end
   end

   always_comb begin
      status_v                  = '0;
      status_v[IM_MSB:IM_LSB]   = im_q;
      status_v[EXL_BIT]         = (state_q == HANDLER);
      status_v[IE_BIT]          = ie_q;
      cause_v                   = '0;
      cause_v[IM_MSB:IM_LSB]    = {ip_hw_q, ip_sw_q};
      cause_v[EXC_MSB:EXC_LSB]  = exc_code_q;

      rd_data = '0;
      case (regnum)
         REG_STATUS: rd_data[15:0] = status_v;
         REG_CAUSE:  rd_data[15:0] = cause_v;
         REG_EPC:    rd_data       = epc_q;
         default:    ;
      endcase
   end

   assign TakenInterrupt = take_exc || take_int;
   assign EPC            = epc_q;
   assign handler_pc     = exceptionVector;

endmodule
